// File: rtl/soc_fpga_ram_pkg.sv
// Shared constants for the SoC FPGA RAM family.
//   RDMODE values  : read-during-write behaviour of Port A
//   INITMODE values: how array contents become defined
//   initState_t    : hardware clear FSM encoding
package soc_fpga_ram_pkg;
  localparam int RD_FIRST  = 0;
  localparam int WR_FIRST  = 1;
  localparam int NO_CHANGE = 2;

  localparam int INIT_NONE  = 0;
  localparam int INIT_FILE  = 1;
  localparam int INIT_CLEAR = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } initState_t;
endpackage

// File: rtl/soc_fpga_ram_init_fsm.sv
// Hardware clear sequencer. It walks every address once after reset,
// issuing a clear write strobe each cycle.
// Ports:
//   PortAClk, PortAResetN : clock, async active-low reset
//   ClearAddr, ClearWe    : clear write port, muxed over Port A by the top
//   InitBusy, InitDone    : clear in progress / contents defined
// For INITMODE other than INIT_CLEAR the FSM resets straight into DONE.
module soc_fpga_ram_init_fsm
  import soc_fpga_ram_pkg::*;
#(
  parameter int ADDRWIDTH = 10,
  parameter int INITMODE  = 0
) (
  input  logic                 PortAClk,
  input  logic                 PortAResetN,
  output logic [ADDRWIDTH-1:0] ClearAddr,
  output logic                 ClearWe,
  output logic                 InitBusy,
  output logic                 InitDone
);
  initState_t           state, stateNext;
  logic [ADDRWIDTH-1:0] cnt, cntNext;

  always_ff @(posedge PortAClk or negedge PortAResetN) begin
    if (!PortAResetN) begin
      state <= (INITMODE == INIT_CLEAR) ? IDLE : DONE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    ClearWe   = 1'b0;
    case (state)
      IDLE: begin
        stateNext = CLEAR;
        cntNext   = '0;
      end
      CLEAR: begin
        ClearWe = 1'b1;
        // last address is written in this cycle, then we are done
        if (cnt == {ADDRWIDTH{1'b1}}) stateNext = DONE;
        else                          cntNext   = cnt + 1'b1;
      end
      default: stateNext = DONE;
    endcase
  end

  assign ClearAddr = cnt;
  assign InitBusy  = (state != DONE);
  assign InitDone  = (state == DONE);
endmodule

// File: rtl/soc_fpga_ram_dp_init.sv
// Simple-dual-port RAM: Port A read/write with byte enables and selectable
// read-during-write, Port B read-only. Optional output register (OUTREG)
// and optional hardware clear after reset.
// Ports:
//   PortAClk, PortAResetN        : shared clock, async active-low reset
//   PortAAddr/DataIn/WriteEnable/ByteEnable/ReadEnable : Port A request
//   PortADataOut, PortADataValid : Port A read response
//   PortBAddr, PortBReadEnable   : Port B request
//   PortBDataOut, PortBDataValid : Port B read response
//   InitBusy, InitDone           : clear status; requests dropped while busy
module soc_fpga_ram_dp_init
  import soc_fpga_ram_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 10,
  parameter int BYTEWIDTH = 8,
  parameter int RDMODE    = 0,
  parameter int OUTREG    = 0,
  parameter int INITMODE  = 0,
  parameter     INITFILE  = "",
  parameter logic [DATAWIDTH-1:0] INITVALUE = '0
) (
  input  logic                           PortAClk,
  input  logic                           PortAResetN,
  input  logic [ADDRWIDTH-1:0]           PortAAddr,
  input  logic [DATAWIDTH-1:0]           PortADataIn,
  input  logic                           PortAWriteEnable,
  input  logic [DATAWIDTH/BYTEWIDTH-1:0] PortAByteEnable,
  input  logic                           PortAReadEnable,
  output logic [DATAWIDTH-1:0]           PortADataOut,
  output logic                           PortADataValid,
  input  logic [ADDRWIDTH-1:0]           PortBAddr,
  input  logic                           PortBReadEnable,
  output logic [DATAWIDTH-1:0]           PortBDataOut,
  output logic                           PortBDataValid,
  output logic                           InitBusy,
  output logic                           InitDone
);
  localparam int NBYTES   = DATAWIDTH / BYTEWIDTH;
  localparam int MEMDEPTH = 2 ** ADDRWIDTH;
  localparam int STAGES   = OUTREG;

  logic [DATAWIDTH-1:0] mem [MEMDEPTH];

  logic [ADDRWIDTH-1:0] clearAddr;
  logic                 clearWe;
  logic                 aWe;
  logic [DATAWIDTH-1:0] aOld, aMerged;

  logic [STAGES:0][DATAWIDTH-1:0] aDataPipe, bDataPipe;
  logic [STAGES:0]                aVldPipe, bVldPipe;

  soc_fpga_ram_init_fsm #(
    .ADDRWIDTH(ADDRWIDTH),
    .INITMODE (INITMODE)
  ) uInitFsm (
    .PortAClk   (PortAClk),
    .PortAResetN(PortAResetN),
    .ClearAddr  (clearAddr),
    .ClearWe    (clearWe),
    .InitBusy   (InitBusy),
    .InitDone   (InitDone)
  );

  assign aWe  = PortAWriteEnable & ~InitBusy;
  assign aOld = mem[PortAAddr];

  // word as it will look after this cycle's masked write (write-first data)
  always_comb begin
    aMerged = aOld;
    for (int i = 0; i < NBYTES; i++)
      if (PortAByteEnable[i])
        aMerged[i*BYTEWIDTH +: BYTEWIDTH] = PortADataIn[i*BYTEWIDTH +: BYTEWIDTH];
  end

  // array is never reset; clear sequencer owns the write port while busy
  always_ff @(posedge PortAClk) begin
    if (clearWe) begin
      mem[clearAddr] <= INITVALUE;
    end else if (aWe) begin
      for (int i = 0; i < NBYTES; i++)
        if (PortAByteEnable[i])
          mem[PortAAddr][i*BYTEWIDTH +: BYTEWIDTH] <= PortADataIn[i*BYTEWIDTH +: BYTEWIDTH];
    end
  end

  // stage 0 is the RAM output register; stages 1..STAGES are OUTREG copies.
  // Port B samples mem before this edge's write lands, so a same-address
  // collision with Port A always returns the old word.
  always_ff @(posedge PortAClk or negedge PortAResetN) begin
    if (!PortAResetN) begin
      aDataPipe <= '0;
      bDataPipe <= '0;
      aVldPipe  <= '0;
      bVldPipe  <= '0;
    end else begin
      aVldPipe[0] <= 1'b0;
      bVldPipe[0] <= 1'b0;
      if (!InitBusy) begin
        if (PortAWriteEnable) begin
          if (RDMODE == WR_FIRST) begin
            aDataPipe[0] <= aMerged;
            aVldPipe[0]  <= 1'b1;
          end else if (RDMODE == RD_FIRST) begin
            aDataPipe[0] <= aOld;
            aVldPipe[0]  <= 1'b1;
          end
        end else if (PortAReadEnable) begin
          aDataPipe[0] <= aOld;
          aVldPipe[0]  <= 1'b1;
        end
        if (PortBReadEnable) begin
          bDataPipe[0] <= mem[PortBAddr];
          bVldPipe[0]  <= 1'b1;
        end
      end
      for (int s = 1; s <= STAGES; s++) begin
        aDataPipe[s] <= aDataPipe[s-1];
        bDataPipe[s] <= bDataPipe[s-1];
        aVldPipe[s]  <= aVldPipe[s-1];
        bVldPipe[s]  <= bVldPipe[s-1];
      end
    end
  end

  assign PortADataOut   = aDataPipe[STAGES];
  assign PortADataValid = aVldPipe[STAGES];
  assign PortBDataOut   = bDataPipe[STAGES];
  assign PortBDataValid = bVldPipe[STAGES];
endmodule

// File: tb/tb_soc_fpga_ram_dp_init.sv
// Four instances share stimulus: 0/1/2 = RDMODE read-first/write-first/
// no-change (OUTREG=0), 3 = read-first with OUTREG=1. All clear to DEADBEEF.
module tb_soc_fpga_ram_dp_init;
  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic [3:0]  aAddr, bAddr, aBe;
  logic [31:0] aDin;
  logic        aWe, aRe, bRe;

  logic [31:0] aDo [4];
  logic [31:0] bDo [4];
  logic        aVl [4];
  logic        bVl [4];
  logic        busy [4];
  logic        done [4];

  int nChk  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gDut
    soc_fpga_ram_dp_init #(
      .DATAWIDTH(32), .ADDRWIDTH(4), .BYTEWIDTH(8),
      .RDMODE((g == 3) ? 0 : g), .OUTREG((g == 3) ? 1 : 0),
      .INITMODE(2), .INITFILE(""), .INITVALUE(32'hDEADBEEF)
    ) u (
      .PortAClk        (clk),
      .PortAResetN     (rstN),
      .PortAAddr       (aAddr),
      .PortADataIn     (aDin),
      .PortAWriteEnable(aWe),
      .PortAByteEnable (aBe),
      .PortAReadEnable (aRe),
      .PortADataOut    (aDo[g]),
      .PortADataValid  (aVl[g]),
      .PortBAddr       (bAddr),
      .PortBReadEnable (bRe),
      .PortBDataOut    (bDo[g]),
      .PortBDataValid  (bVl[g]),
      .InitBusy        (busy[g]),
      .InitDone        (done[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    aAddr = '0; bAddr = '0; aBe = '0; aDin = '0;
    aWe = 1'b0; aRe = 1'b0; bRe = 1'b0;

    // reset state
    #2 rstN = 1'b0;
    #10;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst aDo%0d", g), aDo[g], 32'h0);
      chk($sformatf("rst aVl%0d", g), aVl[g], 1'b0);
      chk($sformatf("rst bDo%0d", g), bDo[g], 32'h0);
      chk($sformatf("rst bVl%0d", g), bVl[g], 1'b0);
      chk($sformatf("rst busy%0d", g), busy[g], 1'b1);
      chk($sformatf("rst done%0d", g), done[g], 1'b0);
    end

    // release, let the clear reach counter 7, then abort with reset
    @(negedge clk) rstN = 1'b1;
    repeat (8) tick;
    chk("busy at cnt7", busy[0], 1'b1);
    rstN = 1'b0;
    #3;
    chk("abort busy", busy[0], 1'b1);
    chk("abort done", done[0], 1'b0);

    // second release: full clear, reads during busy must be ignored
    @(negedge clk) rstN = 1'b1;
    bRe = 1'b1; bAddr = 4'd0;
    cyc = 0;
    while (!done[0] && cyc < 100) begin
      tick;
      cyc++;
      chk("busy bVl0", bVl[0], 1'b0);
      chk("busy bVl3", bVl[3], 1'b0);
    end
    chk("init cycles", cyc, 32'd17);
    chk("busy low", busy[0], 1'b0);
    chk("done3", done[3], 1'b1);

    // Port B sweep, back-to-back
    for (int i = 0; i < 16; i++) begin
      bAddr = i[3:0];
      tick;
      chk($sformatf("clr b0 a%0d", i), bDo[0], 32'hDEADBEEF);
      chk($sformatf("clr bv0 a%0d", i), bVl[0], 1'b1);
      if (i > 0) begin
        chk($sformatf("clr b3 a%0d", i-1), bDo[3], 32'hDEADBEEF);
        chk($sformatf("clr bv3 a%0d", i-1), bVl[3], 1'b1);
      end
    end
    bRe = 1'b0;
    tick;
    chk("clr b3 a15", bDo[3], 32'hDEADBEEF);
    chk("clr bv3 a15", bVl[3], 1'b1);
    chk("b idle vld", bVl[0], 1'b0);
    chk("b idle hold", bDo[0], 32'hDEADBEEF);
    tick;

    // Port A read, then full and masked writes under each RDMODE
    aRe = 1'b1; aAddr = 4'd5;
    tick;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("a rd5 d%0d", g), aDo[g], 32'hDEADBEEF);
      chk($sformatf("a rd5 v%0d", g), aVl[g], 1'b1);
    end
    aRe = 1'b0; aWe = 1'b1; aAddr = 4'd3; aDin = 32'h11223344; aBe = 4'hF;
    tick;
    chk("wr full rf d", aDo[0], 32'hDEADBEEF);
    chk("wr full rf v", aVl[0], 1'b1);
    chk("wr full wf d", aDo[1], 32'h11223344);
    chk("wr full wf v", aVl[1], 1'b1);
    chk("wr full nc d", aDo[2], 32'hDEADBEEF);
    chk("wr full nc v", aVl[2], 1'b0);
    aRe = 1'b1; aDin = 32'hAABBCCDD; aBe = 4'b0101;
    tick;
    chk("wr mask rf d", aDo[0], 32'h11223344);
    chk("wr mask rf v", aVl[0], 1'b1);
    chk("wr mask wf d", aDo[1], 32'h11BB33DD);
    chk("wr mask wf v", aVl[1], 1'b1);
    chk("wr mask nc d", aDo[2], 32'hDEADBEEF);
    chk("wr mask nc v", aVl[2], 1'b0);
    aRe = 1'b0; aDin = 32'hFFFFFFFF; aBe = 4'b0000;
    tick;
    chk("wr zero rf d", aDo[0], 32'h11BB33DD);
    chk("wr zero wf d", aDo[1], 32'h11BB33DD);
    chk("wr zero nc v", aVl[2], 1'b0);
    aWe = 1'b0; aRe = 1'b1;
    tick;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("a rd3 d%0d", g), aDo[g], 32'h11BB33DD);
      chk($sformatf("a rd3 v%0d", g), aVl[g], 1'b1);
    end
    aRe = 1'b0;
    tick;
    chk("a idle vld", aVl[0], 1'b0);
    chk("a idle hold", aDo[0], 32'h11BB33DD);
    chk("a rd3 oreg d", aDo[3], 32'h11BB33DD);
    chk("a rd3 oreg v", aVl[3], 1'b1);

    // A/B same-address collision returns the old word on B
    aWe = 1'b1; aBe = 4'hF; aAddr = 4'd9; aDin = 32'h0;
    tick;
    aDin = 32'h5; bRe = 1'b1; bAddr = 4'd9;
    tick;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("coll b d%0d", g), bDo[g], 32'h0);
      chk($sformatf("coll b v%0d", g), bVl[g], 1'b1);
    end
    aWe = 1'b0;
    tick;
    chk("after coll d", bDo[0], 32'h5);
    chk("after coll v", bVl[0], 1'b1);
    bRe = 1'b0;

    // OUTREG latency/throughput on Port B
    aWe = 1'b1; aAddr = 4'd1; aDin = 32'h101;
    tick;
    aAddr = 4'd2; aDin = 32'h202;
    tick;
    aAddr = 4'd3; aDin = 32'h303;
    tick;
    aWe = 1'b0;
    tick;
    tick;
    bRe = 1'b1; bAddr = 4'd1;
    tick;
    chk("oreg c1 v", bVl[3], 1'b0);
    bAddr = 4'd2;
    tick;
    chk("oreg c2 d", bDo[3], 32'h101);
    chk("oreg c2 v", bVl[3], 1'b1);
    bAddr = 4'd3;
    tick;
    chk("oreg c3 d", bDo[3], 32'h202);
    chk("oreg c3 v", bVl[3], 1'b1);
    bRe = 1'b0;
    tick;
    chk("oreg c4 d", bDo[3], 32'h303);
    chk("oreg c4 v", bVl[3], 1'b1);
    tick;
    chk("oreg c5 v", bVl[3], 1'b0);
    chk("oreg c5 hold", bDo[3], 32'h303);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
